// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational alu between two requesters.
// Operands and results are registered; completed responses are counted.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [DATA_WIDTH-1:0] a_op1,
    input  logic [DATA_WIDTH-1:0] a_op2,
    input  logic [CTRL_WIDTH-1:0] a_ctrl,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [DATA_WIDTH-1:0] b_op1,
    input  logic [DATA_WIDTH-1:0] b_op2,
    input  logic [CTRL_WIDTH-1:0] b_ctrl,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_zero,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_b;
    logic                  owner_b;
    logic                  grant_a;
    logic                  grant_b;
    logic                  rsp_take;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;

    // Round-robin grant: A wins a tie only when B was served last.
    always_comb begin
        grant_a  = (state == IDLE) && a_req_valid
                   && (!b_req_valid || last_b);
        grant_b  = (state == IDLE) && b_req_valid && !grant_a;
        rsp_take = (state == RESP)
                   && (owner_b ? b_rsp_ready : a_rsp_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one cycle in EXEC, RESP waits for the owner.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_a || grant_b) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the arbitration result.
    always_comb begin
        a_req_ready = grant_a;
        b_req_ready = grant_b;
        a_rsp_valid = (state == RESP) && !owner_b;
        b_rsp_valid = (state == RESP) && owner_b;
        busy        = (state != IDLE);
    end

    // Operand capture on accept; held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q   <= '0;
            op2_q   <= '0;
            ctrl_q  <= '0;
            owner_b <= 1'b0;
            last_b  <= 1'b1;
        end else if (grant_a) begin
            op1_q   <= a_op1;
            op2_q   <= a_op2;
            ctrl_q  <= a_ctrl;
            owner_b <= 1'b0;
            last_b  <= 1'b0;
        end else if (grant_b) begin
            op1_q   <= b_op1;
            op2_q   <= b_op2;
            ctrl_q  <= b_ctrl;
            owner_b <= 1'b1;
            last_b  <= 1'b1;
        end
    end

    // Result capture in EXEC and completion counting in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == EXEC) begin
                rsp_data <= alu_result;
                rsp_zero <= alu_zero;
            end
            if (rsp_take) op_count <= op_count + 1'b1;
        end
    end

    assign alu_op1  = op1_q;
    assign alu_op2  = op2_q;
    assign alu_ctrl = ctrl_q;

endmodule
